// File: rtl/sound_envelope.sv
// Volume envelope generator stepped by a 64 Hz tick derived from clock_64.
// Build macro SOUND_ENV_SYNC_EN: adds SYNC_STAGES synchronizer flops on clock_64.
module sound_envelope #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clock_64,
   input  logic       trigger,
   input  logic [3:0] init_volume,
   input  logic       env_dir,
   input  logic [2:0] env_period,
   output logic [3:0] volume,
   output logic       env_active,
   output logic       env_tick
);

`ifdef SOUND_ENV_SYNC_EN
   localparam int STAGES = SYNC_STAGES;
`else
   // clock_64 is treated as synchronous: one sampling register only
   localparam int STAGES = 1;
`endif

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              dir_q;
   logic [2:0]        period_q;
   logic [2:0]        count_q;

   logic [3:0] volume_n;
   logic       active_n;
   logic       dir_n;
   logic [2:0] period_n;
   logic [2:0] count_n;
   logic       at_limit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         env_tick <= 1'b0;
      end else begin
         sync_q[0] <= clock_64;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q   <= sync_q[STAGES-1];
         env_tick <= sync_q[STAGES-1] & ~prev_q;
      end
   end

   assign at_limit = dir_q ? (volume == 4'hF) : (volume == 4'h0);

   // Trigger wins over a coincident tick; the tick is simply lost.
   always_comb begin
      volume_n = volume;
      active_n = env_active;
      dir_n    = dir_q;
      period_n = period_q;
      count_n  = count_q;
      if (trigger) begin
         volume_n = init_volume;
         dir_n    = env_dir;
         period_n = env_period;
         count_n  = env_period;
         active_n = (env_period != 3'd0);
      end else if (env_tick && env_active) begin
         if (count_q > 3'd1) begin
            count_n = count_q - 3'd1;
         end else begin
            count_n = period_q;
            if (at_limit) active_n = 1'b0;
            else if (dir_q) volume_n = volume + 4'd1;
            else volume_n = volume - 4'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         volume     <= 4'd0;
         env_active <= 1'b0;
         dir_q      <= 1'b0;
         period_q   <= 3'd0;
         count_q    <= 3'd0;
      end else begin
         volume     <= volume_n;
         env_active <= active_n;
         dir_q      <= dir_n;
         period_q   <= period_n;
         count_q    <= count_n;
      end
   end

endmodule

// File: tb/tb_sound_envelope.sv
// Self-checking bench for sound_envelope with a tick-count envelope model.
module tb_sound_envelope;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       clock_64 = 1'b0;
   logic       trigger = 1'b0;
   logic [3:0] init_volume = 4'd0;
   logic       env_dir = 1'b0;
   logic [2:0] env_period = 3'd0;
   logic [3:0] volume;
   logic       env_active;
   logic       env_tick;

   int passed = 0;
   int total = 0;
   int tick_seen = 0;

`ifdef SOUND_ENV_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   // model: envelope parameters captured at the last trigger plus ticks since
   int m_init, m_dir, m_per, m_ticks;

   sound_envelope #(.SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .clock_64(clock_64), .trigger(trigger),
      .init_volume(init_volume), .env_dir(env_dir), .env_period(env_period),
      .volume(volume), .env_active(env_active), .env_tick(env_tick)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (env_tick === 1'b1) tick_seen++;

   function automatic int m_steps();
      return (m_per == 0) ? 0 : m_ticks / m_per;
   endfunction

   function automatic int m_dist();
      return m_dir ? 15 - m_init : m_init;
   endfunction

   function automatic logic [3:0] model_vol();
      int s = m_steps();
      int d = m_dist();
      int n = (s < d) ? s : d;
      return 4'(m_dir ? m_init + n : m_init - n);
   endfunction

   function automatic logic model_act();
      return (m_per != 0) && (m_steps() <= m_dist());
   endfunction

   task automatic do_trigger(input int iv, input int d, input int p);
      @(negedge clock);
      init_volume = 4'(iv);
      env_dir     = 1'(d);
      env_period  = 3'(p);
      trigger     = 1'b1;
      @(negedge clock);
      trigger     = 1'b0;
      init_volume = 4'($urandom_range(15, 0));
      env_dir     = 1'($urandom_range(1, 0));
      env_period  = 3'($urandom_range(7, 0));
      m_init = iv; m_dir = d; m_per = p; m_ticks = 0;
   endtask

   task automatic c64_edge();
      @(negedge clock);
      clock_64 = 1'b1;
      repeat ($urandom_range(8, 5)) @(negedge clock);
      clock_64 = 1'b0;
      repeat ($urandom_range(8, 5)) @(negedge clock);
      m_ticks++;
   endtask

   task automatic test_reset();
      clock_64 = 1'b1;
      repeat (3) @(negedge clock);
      total++;
      if (volume !== 4'd0) $display("FAIL reset_volume got %0d want 0", volume); else passed++;
      total++;
      if (env_active !== 1'b0) $display("FAIL reset_active got %0b want 0", env_active); else passed++;
      total++;
      if (env_tick !== 1'b0) $display("FAIL reset_tick got %0b want 0", env_tick); else passed++;
      tick_seen = 0;
      reset = 1'b1;
      repeat (10) @(negedge clock);
      total++;
      if (tick_seen !== 1) $display("FAIL reset_release_ticks got %0d want 1", tick_seen); else passed++;
      total++;
      if (volume !== 4'd0 || env_active !== 1'b0)
         $display("FAIL reset_release_state got vol %0d act %0b want 0 0", volume, env_active);
      else passed++;
      clock_64 = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   task automatic test_ramp_up();
      do_trigger(0, 1, 1);
      for (int e = 1; e <= 16; e++) begin
         c64_edge();
         total++;
         if (volume !== model_vol())
            $display("FAIL ramp_up_vol edge %0d got %0d want %0d", e, volume, model_vol());
         else passed++;
      end
      total++;
      if (env_active !== 1'b0 || volume !== 4'd15)
         $display("FAIL ramp_up_end got vol %0d act %0b want 15 0", volume, env_active);
      else passed++;
   endtask

   task automatic test_ramp_down();
      do_trigger(15, 0, 3);
      for (int e = 1; e <= 9; e++) begin
         c64_edge();
         if (e % 3 == 0) begin
            total++;
            if (volume !== 4'(15 - e / 3))
               $display("FAIL ramp_down edge %0d got %0d want %0d", e, volume, 15 - e / 3);
            else passed++;
         end
      end
      total++;
      if (env_active !== 1'b1) $display("FAIL ramp_down_active got %0b want 1", env_active); else passed++;
   endtask

   task automatic test_frozen();
      do_trigger(7, 1, 0);
      tick_seen = 0;
      repeat (10) c64_edge();
      total++;
      if (volume !== 4'd7 || env_active !== 1'b0)
         $display("FAIL frozen_state got vol %0d act %0b want 7 0", volume, env_active);
      else passed++;
      total++;
      if (tick_seen !== 10) $display("FAIL frozen_ticks got %0d want 10", tick_seen); else passed++;
   endtask

   task automatic test_coincident();
      bit found = 0;
      do_trigger(9, 1, 1);
      @(negedge clock);
      clock_64 = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (env_tick === 1'b1) found = 1;
      end
      total++;
      if (!found) $display("FAIL coincident_tick_timeout got no tick want tick");
      else passed++;
      total++;
      if (volume !== 4'd9) $display("FAIL coincident_pre got %0d want 9", volume); else passed++;
      init_volume = 4'd4; env_dir = 1'b1; env_period = 3'd2; trigger = 1'b1;
      m_init = 4; m_dir = 1; m_per = 2; m_ticks = 0;
      @(posedge clock); #1;
      total++;
      if (volume !== 4'd4) $display("FAIL coincident_load got %0d want 4", volume); else passed++;
      @(negedge clock);
      trigger = 1'b0;
      repeat (6) @(negedge clock);
      clock_64 = 1'b0;
      repeat (6) @(negedge clock);
      for (int e = 1; e <= 2; e++) begin
         c64_edge();
         total++;
         if (volume !== model_vol())
            $display("FAIL coincident_step edge %0d got %0d want %0d", e, volume, model_vol());
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      do_trigger(3, 1, 1);
      repeat (3) c64_edge();
      total++;
      if (volume !== 4'd6) $display("FAIL mid_pre got %0d want 6", volume); else passed++;
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      total++;
      if (volume !== 4'd0 || env_active !== 1'b0)
         $display("FAIL mid_async got vol %0d act %0b want 0 0", volume, env_active);
      else passed++;
      @(negedge clock);
      reset = 1'b1;
      repeat (3) c64_edge();
      total++;
      if (volume !== 4'd0 || env_active !== 1'b0)
         $display("FAIL mid_after got vol %0d act %0b want 0 0", volume, env_active);
      else passed++;
   endtask

   task automatic test_latency();
      do_trigger(5, 1, 1);
      @(negedge clock);
      clock_64 = 1'b1;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(posedge clock); #1;
         if (k == LAT) begin
            total++;
            if (volume !== 4'd5) $display("FAIL latency_early edge %0d got %0d want 5", k, volume);
            else passed++;
         end
         if (k == LAT + 1) begin
            total++;
            if (volume !== 4'd6) $display("FAIL latency_step edge %0d got %0d want 6", k, volume);
            else passed++;
         end
      end
      repeat (4) @(negedge clock);
      clock_64 = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int n = $urandom_range(20, 0);
         do_trigger($urandom_range(15, 0), $urandom_range(1, 0), $urandom_range(7, 0));
         for (int e = 0; e < n; e++) begin
            c64_edge();
            total++;
            if (volume !== model_vol() || env_active !== model_act())
               $display("FAIL random it %0d edge %0d got vol %0d act %0b want %0d %0b",
                        it, e, volume, env_active, model_vol(), model_act());
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_frozen();
      test_coincident();
      test_reset_mid();
      test_latency();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
